// File: rtl/button_mode_sel_pkg.sv
// Shared definitions for the front-panel mode select path.
// Mode encodings are also consumed by the LED blinker.
package button_mode_sel_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_BTN = 2;

  localparam logic [SEL_W-1:0] SEL_FOLLOW = 2'b00;
  localparam logic [SEL_W-1:0] SEL_INVERT = 2'b01;
  localparam logic [SEL_W-1:0] SEL_OFF    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ON     = 2'b11;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_mode_sel_debounce.sv
// Single-button conditioner: 2-flop synchroniser, polarity normalisation,
// tick-driven debounce and press-edge pulse.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   pin            : raw asynchronous button pin
//   tick           : shared prescaler strobe, one clock wide
//   pressed        : debounced level, 1 = pressed
//   press          : one-clock pulse on debounced release->press
module btn_debounce
  import button_mode_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned BTN_ACTIVE_LOW = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  input  logic tick,
  output logic pressed,
  output logic press
);

  localparam int unsigned CNT_W    = cnt_width(DEBOUNCE);
  localparam logic        IDLE_LVL = (BTN_ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pressed_d;
  logic             press_d;
  logic             lvl_c;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{IDLE_LVL}};
    else          sync_q <= {sync_q[0], pin};
  end

  assign lvl_c = sync_q[1] ^ IDLE_LVL;

  // Debounce: a differing level must be seen on DEBOUNCE consecutive ticks.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed;
    press_d   = 1'b0;
    if (tick) begin
      if (lvl_c == pressed) begin
        cnt_d = '0;
      end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
        cnt_d     = '0;
        pressed_d = lvl_c;
        press_d   = lvl_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pressed <= pressed_d;
      press   <= press_d;
    end
  end

endmodule

// File: rtl/button_mode_sel.sv
// Two-button front-panel mode selector feeding the blinker's sel input.
// btn[0] steps the mode forward, btn[1] steps it back, and a long hold of
// btn[0] forces the mode back to SEL_FOLLOW.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   btn[1:0]       : raw asynchronous pins, [0]=next, [1]=prev
//   sel[1:0]       : registered mode select
//   pressed[1:0]   : debounced levels, 1 = pressed
//   press[1:0]     : one-clock press-edge pulses
//   long_press     : one-clock pulse when btn[0] has been held LONG_TICKS ticks
module button_mode_sel
  import button_mode_sel_pkg::*;
#(
  parameter int unsigned DIV_BITS       = 16,
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned LONG_TICKS     = 64,
  parameter int unsigned BTN_ACTIVE_LOW = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       btn,
  output logic [SEL_W-1:0] sel,
  output logic [1:0]       pressed,
  output logic [1:0]       press,
  output logic             long_press
);

  localparam int unsigned LONG_W = cnt_width(LONG_TICKS);

  logic [DIV_BITS-1:0] div_q;
  logic                tick_c;
  logic [LONG_W-1:0]   long_cnt_q;
  logic [LONG_W-1:0]   long_cnt_d;
  logic                long_d;
  logic [SEL_W-1:0]    sel_d;

  // Free-running prescaler; tick while all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_q + DIV_BITS'(1);
  end

  assign tick_c = &div_q;

  btn_debounce #(
    .DEBOUNCE       (DEBOUNCE),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_next (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (btn[0]),
    .tick    (tick_c),
    .pressed (pressed[0]),
    .press   (press[0])
  );

  btn_debounce #(
    .DEBOUNCE       (DEBOUNCE),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_prev (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (btn[1]),
    .tick    (tick_c),
    .pressed (pressed[1]),
    .press   (press[1])
  );

  // Long-hold counter saturates, so the pulse fires once per hold.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (!pressed[0]) begin
      long_cnt_d = '0;
    end else if (tick_c && (long_cnt_q != LONG_W'(LONG_TICKS))) begin
      long_cnt_d = long_cnt_q + LONG_W'(1);
      long_d     = (long_cnt_d == LONG_W'(LONG_TICKS));
    end
  end

  // Mode update from last clock's pulses; long press has top priority.
  always_comb begin
    sel_d = sel;
    if (long_press) begin
      sel_d = SEL_FOLLOW;
    end else begin
      case (press)
        2'b01:   sel_d = sel + SEL_W'(1);
        2'b10:   sel_d = sel - SEL_W'(1);
        default: sel_d = sel;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt_q <= '0;
      long_press <= 1'b0;
      sel        <= SEL_FOLLOW;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_press <= long_d;
      sel        <= sel_d;
    end
  end

endmodule

// File: tb/tb_button_mode_sel.sv
// Directed bench for button_mode_sel with a fast prescaler.
module tb_button_mode_sel;

  localparam int unsigned DIV_BITS       = 2;
  localparam int unsigned DEBOUNCE       = 3;
  localparam int unsigned LONG_TICKS     = 8;
  localparam int unsigned BTN_ACTIVE_LOW = 1;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] btn;
  logic [1:0] sel;
  logic [1:0] pressed;
  logic [1:0] press;
  logic       long_press;

  always #5 clock = ~clock;

  button_mode_sel #(
    .DIV_BITS       (DIV_BITS),
    .DEBOUNCE       (DEBOUNCE),
    .LONG_TICKS     (LONG_TICKS),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .btn        (btn),
    .sel        (sel),
    .pressed    (pressed),
    .press      (press),
    .long_press (long_press)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt_p0, cnt_p1, cnt_both, cnt_long;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (press[0])        cnt_p0++;
    if (press[1])        cnt_p1++;
    if (press == 2'b11)  cnt_both++;
    if (long_press)      cnt_long++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] btn;
    bit         bounce;
    int         cycles;
    logic [1:0] sel;
    logic [1:0] pressed;
    int         p0;
    int         p1;
    int         both;
    int         lng;
  } vec_t;

  vec_t vecs[21];
  int   edges;

  initial begin
    // Active-low pins: 1 = released.
    vecs[0]  = '{2'b11, 1'b0, 100, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[1]  = '{2'b10, 1'b0,  20, 2'b01, 2'b01, 1, 0, 0, 0};
    vecs[2]  = '{2'b11, 1'b0,  20, 2'b01, 2'b00, 0, 0, 0, 0};
    vecs[3]  = '{2'b10, 1'b0,  20, 2'b10, 2'b01, 1, 0, 0, 0};
    vecs[4]  = '{2'b11, 1'b0,  20, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[5]  = '{2'b10, 1'b0,  20, 2'b11, 2'b01, 1, 0, 0, 0};
    vecs[6]  = '{2'b11, 1'b0,  20, 2'b11, 2'b00, 0, 0, 0, 0};
    vecs[7]  = '{2'b10, 1'b0,  20, 2'b00, 2'b01, 1, 0, 0, 0};
    vecs[8]  = '{2'b11, 1'b0,  20, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[9]  = '{2'b01, 1'b0,  20, 2'b11, 2'b10, 0, 1, 0, 0};
    vecs[10] = '{2'b11, 1'b0,  20, 2'b11, 2'b00, 0, 0, 0, 0};
    vecs[11] = '{2'b11, 1'b1,  40, 2'b11, 2'b00, 0, 0, 0, 0};
    vecs[12] = '{2'b01, 1'b0,  20, 2'b10, 2'b10, 0, 1, 0, 0};
    vecs[13] = '{2'b11, 1'b0,  20, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[14] = '{2'b00, 1'b0,  20, 2'b10, 2'b11, 1, 1, 1, 0};
    vecs[15] = '{2'b11, 1'b0,  20, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[16] = '{2'b10, 1'b0,  60, 2'b00, 2'b01, 1, 0, 0, 1};
    vecs[17] = '{2'b10, 1'b0,  60, 2'b00, 2'b01, 0, 0, 0, 0};
    vecs[18] = '{2'b11, 1'b0,  20, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[19] = '{2'b10, 1'b0,  60, 2'b00, 2'b01, 1, 0, 0, 1};
    vecs[20] = '{2'b11, 1'b0,  20, 2'b00, 2'b00, 0, 0, 0, 0};

    reset_n = 1'b0;
    btn     = 2'b11;
    repeat (3) @(negedge clock);
    check("reset sel", sel, 0);
    check("reset pressed", pressed, 0);
    check("reset press", press, 0);
    check("reset long_press", long_press, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      cnt_p0 = 0; cnt_p1 = 0; cnt_both = 0; cnt_long = 0;
      for (int k = 0; k < vecs[i].cycles; k++) begin
        if (vecs[i].bounce) btn = {(((k / 3) % 2) == 0) ? 1'b0 : 1'b1, 1'b1};
        else                btn = vecs[i].btn;
        @(negedge clock);
      end
      check($sformatf("v%0d sel", i), sel, vecs[i].sel);
      check($sformatf("v%0d pressed", i), pressed, vecs[i].pressed);
      check($sformatf("v%0d press0 count", i), cnt_p0, vecs[i].p0);
      check($sformatf("v%0d press1 count", i), cnt_p1, vecs[i].p1);
      check($sformatf("v%0d both count", i), cnt_both, vecs[i].both);
      check($sformatf("v%0d long count", i), cnt_long, vecs[i].lng);
    end

    // Press latency bound, pulse width and sel one clock later.
    @(negedge clock);
    btn   = 2'b10;
    edges = 0;
    while (!press[0] && edges < 30) begin
      @(posedge clock); #1; edges++;
    end
    check("latency within 14", int'(edges <= 14), 1);
    check("press0 high", press[0], 1);
    check("pressed0 with press", pressed[0], 1);
    check("sel before update", sel, 0);
    @(posedge clock); #1;
    check("press0 one clock", press[0], 0);
    check("sel after update", sel, 1);
    btn = 2'b11;
    repeat (20) @(negedge clock);
    check("released before reset test", pressed, 0);

    // Reset mid-debounce, button held through release.
    btn = 2'b10;
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async reset sel", sel, 0);
    check("async reset pressed", pressed, 0);
    check("async reset press", press, 0);
    check("async reset long", long_press, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    while (!press[0] && edges < 30) begin
      @(posedge clock); #1; edges++;
    end
    check("post-reset debounce edges", edges, 12);
    @(posedge clock); #1;
    check("post-reset sel", sel, 1);
    btn = 2'b11;
    repeat (20) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_mode_sel.md
Name: button_mode_sel

Overview:
- Input-side counterpart of the LED blinker: turns two raw front-panel pushbuttons into the 2-bit mode select the blinker consumes.
- Per button: synchronises, debounces on a slow prescaler tick, detects press edges and long presses.
- Maintains a wrapping 2-bit mode register.
- Sits between board button pins and the blinker's sel input.

Parameters:
DIV_BITS, 16, prescaler width; one debounce tick every 2^DIV_BITS clocks.
DEBOUNCE, 4, consecutive ticks a new level must persist before it is accepted (>=1).
LONG_TICKS, 64, ticks button 0 must stay debounced-pressed to count as a long press (>DEBOUNCE).
BTN_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn  in  2  raw asynchronous button pins; [0]=next, [1]=prev
sel  out  2  registered mode select to blinker (00 follow, 01 invert, 10 off, 11 on)
pressed  out  2  debounced level per button, 1 = pressed
press  out  2  one-clock pulse on each debounced release->press transition
long_press  out  1  one-clock pulse when button 0 reaches LONG_TICKS held

Behaviour:
- Reset (reset_n low, async assert, sync release): sel=00, pressed=00, press=00, long_press=0, prescaler=0, debounce counters=0, long counter=0. Sync flops reset to the released pin level (1 if BTN_ACTIVE_LOW), so no spurious press after reset.
- Synchroniser: 2 flops per button, then polarity-normalised (1 = pressed). Raw-to-synced latency: 2 clocks.
- Prescaler: free-running DIV_BITS-bit up counter, wraps. tick = 1 for exactly one clock when the counter is all-ones.
- Debounce, per button, on each tick only:
  - synced == pressed: clear the counter.
  - synced != pressed: increment the counter. When the incremented value equals DEBOUNCE, toggle pressed and clear the counter.
  - Any glitch back to the old level on a tick restarts the count.
  - Non-tick clocks hold all debounce state.
- press[i]: asserted in the same clock edge that sets pressed[i] 0->1. Exactly one clock wide. Never asserted on a release.
- Long press (button 0 only):
  - Counter clears while pressed[0]=0.
  - Increments on each tick while pressed[0]=1, saturating at LONG_TICKS.
  - long_press pulses for one clock on the tick where the counter first reaches LONG_TICKS. Only once per hold; re-arms only after release.
- sel update, registered, one clock after the causing pulse, evaluated in priority order:
  - long_press -> sel=00 (wins over everything).
  - press[0] and press[1] together -> sel unchanged.
  - press[0] alone -> sel+1 mod 4 (11 wraps to 00).
  - press[1] alone -> sel-1 mod 4 (00 wraps to 11).
- A long press always follows its own press[0] increment. Net effect of a long hold: sel forced to 00.
- Reset mid-debounce or mid-hold discards all progress; a button held through reset release must be re-debounced from scratch. It then produces one press pulse DEBOUNCE ticks later.
- Worst-case latency, pin edge to press: 2 + DEBOUNCE*2^DIV_BITS clocks. Best case: 2 + (DEBOUNCE-1)*2^DIV_BITS + 1.

Decomposition:
- Shared package: sel mode constants (SEL_FOLLOW=00, SEL_INVERT=01, SEL_OFF=10, SEL_ON=11), reused by the blinker. Also the prescaler tick helper width.
- One natural sub-module: btn_debounce. It holds the synchroniser, polarity, debounce counter and pressed/press outputs, and is instantiated twice with a shared tick input.
- Prescaler, long-press counter and sel register stay in the top.

Test Plan (sim params DIV_BITS=2, DEBOUNCE=3, LONG_TICKS=8, BTN_ACTIVE_LOW=1):
- Reset with btn=11 held, release reset -> sel=00, pressed=00, no press pulse for 100 clocks.
- Drive btn[0]=0 cleanly -> pressed[0] rises within 2+12 clocks, press[0] one clock wide; next clock sel=01. Three more clean presses -> sel 10, 11, 00 (wrap).
- From sel=00, clean press of btn[1] -> sel=11; pin bounces 0/1 every 3 clocks for 40 clocks, then stable 0 -> exactly one press[1], sel decrements exactly once.
- Press both buttons with identical timing -> press=11 in the same clock, sel unchanged.
- Hold btn[0] low 8+ ticks past debounce, starting from sel=10 -> press[0] (sel=11), then long_press once (sel=00). No second long_press while still held; release and re-press re-arms it.
- Assert reset_n low 2 ticks into a debounce of btn[0] (still held) -> all outputs 0 immediately (async). After release, press[0] appears only after a full 3-tick debounce.
